// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_arbiter
// Description : Write-back controller for the register file. Round-robin
//               arbitration of the single write port between the ALU and
//               load result paths (valid/ready), registered write port
//               outputs, and a per-register busy scoreboard that stalls
//               issue on RAW and WAW hazards against pending writes.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter #(
  parameter int NUM_REG        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  // ALU result path
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]      alu_data,
  output logic                      alu_ready,
  // Load result path
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [REG_WIDTH-1:0]      mem_data,
  output logic                      mem_ready,
  // Register file write port
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] addr_rd,
  output logic [REG_WIDTH-1:0]      data_rd,
  // Issue interface
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_wb,
  output logic                      issue_stall,
  output logic [NUM_REG-1:0]        busy
);

  // Identity of the requester granted most recently.
  typedef enum logic [0:0] {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  localparam logic [REG_ADDR_WIDTH-1:0] c_ZERO_REG = '0;

  grant_t                      last_q, last_d;
  logic                        wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0]   addr_rd_q, addr_rd_d;
  logic [REG_WIDTH-1:0]        data_rd_q, data_rd_d;
  logic [NUM_REG-1:0]          busy_q, busy_d;

  logic                        w_alu_grant;
  logic                        w_mem_grant;
  logic                        w_fire;
  logic [REG_ADDR_WIDTH-1:0]   w_grant_rd;
  logic [REG_WIDTH-1:0]        w_grant_data;
  logic                        w_issue_accept;

  // Round-robin grant: a lone requester wins; on conflict the requester not
  // granted last time wins. Readies are held low while reset is asserted.
  always_comb begin
    w_alu_grant = 1'b0;
    w_mem_grant = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        w_alu_grant = (last_q == GRANT_MEM);
        w_mem_grant = (last_q == GRANT_ALU);
      end else begin
        w_alu_grant = alu_valid;
        w_mem_grant = mem_valid;
      end
    end
  end

  assign alu_ready = w_alu_grant;
  assign mem_ready = w_mem_grant;
  assign w_fire    = w_alu_grant | w_mem_grant;

  // Select the granted request's destination and data, and update the
  // last-grant pointer whenever any transfer fires (including rd == 0).
  always_comb begin
    last_d       = last_q;
    w_grant_rd   = alu_rd;
    w_grant_data = alu_data;
    if (w_mem_grant) begin
      w_grant_rd   = mem_rd;
      w_grant_data = mem_data;
      last_d       = GRANT_MEM;
    end else if (w_alu_grant) begin
      last_d       = GRANT_ALU;
    end
  end

  // Write port: load for one cycle on a grant to a real register; a write to
  // x0 is swallowed. Address and data hold when no write is launched.
  always_comb begin
    wr_en_d   = 1'b0;
    addr_rd_d = addr_rd_q;
    data_rd_d = data_rd_q;
    if (w_fire && (w_grant_rd != c_ZERO_REG)) begin
      wr_en_d   = 1'b1;
      addr_rd_d = w_grant_rd;
      data_rd_d = w_grant_data;
    end
  end

  // Hazard check against pending writes; x0 never reads as busy because
  // busy_q[0] is held at zero.
  always_comb begin
    issue_stall = issue_valid &
                  (busy_q[issue_rs1] | busy_q[issue_rs2] |
                   (issue_wb & busy_q[issue_rd]));
  end

  assign w_issue_accept = issue_valid & issue_wb & ~issue_stall &
                          (issue_rd != c_ZERO_REG);

  // Scoreboard next state: clear on the edge the register file captures the
  // write, then apply the issue set so a same-edge set takes precedence.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[addr_rd_q] = 1'b0;
    end
    if (w_issue_accept) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous reset; a pending write is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= GRANT_MEM;
      wr_en_q   <= 1'b0;
      addr_rd_q <= '0;
      data_rd_q <= '0;
      busy_q    <= '0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      addr_rd_q <= addr_rd_d;
      data_rd_q <= data_rd_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign addr_rd = addr_rd_q;
  assign data_rd = data_rd_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_arbiter
// Description : Directed self-checking bench for reg_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wr_en;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_wb;
  logic        issue_stall;
  logic [31:0] busy;

  int tests;
  int errors;

  reg_wb_arbiter #(
    .NUM_REG        (32),
    .REG_ADDR_WIDTH (5),
    .REG_WIDTH      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .wr_en       (wr_en),
    .addr_rd     (addr_rd),
    .data_rd     (data_rd),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_wb    (issue_wb),
    .issue_stall (issue_stall),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests       = 0;
    errors      = 0;
    reset       = 1'b1;
    alu_valid   = 1'b1;
    alu_rd      = 5'd4;
    alu_data    = 32'h0;
    mem_valid   = 1'b1;
    mem_rd      = 5'd6;
    mem_data    = 32'h0;
    issue_valid = 1'b0;
    issue_rs1   = 5'd0;
    issue_rs2   = 5'd0;
    issue_rd    = 5'd0;
    issue_wb    = 1'b0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", addr_rd, 0);
    check("rst_data", data_rd, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);

    // ---------------- Single ALU write ----------------
    reset     = 1'b0;
    mem_valid = 1'b0;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    #1;
    check("alu_ready_single", alu_ready, 1);
    check("mem_ready_single", mem_ready, 0);
    tick();
    alu_valid = 1'b0;
    check("single_wr_en", wr_en, 1);
    check("single_addr", addr_rd, 5);
    check("single_data", data_rd, 32'hDEADBEEF);
    tick();
    check("single_wr_en_drop", wr_en, 0);
    check("single_addr_hold", addr_rd, 5);
    check("single_data_hold", data_rd, 32'hDEADBEEF);

    // ---------------- Round robin after fresh reset ----------------
    reset = 1'b1;
    #2;
    reset = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = 32'h000000A1;
    mem_valid = 1'b1;
    mem_rd    = 5'd2;
    mem_data  = 32'h000000B2;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_alu_ready_%0d", k), alu_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr_mem_ready_%0d", k), mem_ready, (k % 2 == 0) ? 0 : 1);
      tick();
      check($sformatf("rr_wr_en_%0d", k), wr_en, 1);
      check($sformatf("rr_addr_%0d", k), addr_rd, (k % 2 == 0) ? 1 : 2);
      check($sformatf("rr_data_%0d", k), data_rd, (k % 2 == 0) ? 32'hA1 : 32'hB2);
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    check("rr_idle_wr_en", wr_en, 0);

    // ---------------- Scoreboard RAW stall ----------------
    issue_valid = 1'b1;
    issue_wb    = 1'b1;
    issue_rd    = 5'd7;
    #1;
    check("sb_issue_no_stall", issue_stall, 0);
    tick();
    check("sb_busy7_set", busy, 32'h0000_0080);
    issue_wb  = 1'b0;
    issue_rd  = 5'd0;
    issue_rs1 = 5'd7;
    #1;
    check("sb_raw_stall", issue_stall, 1);
    tick();
    check("sb_raw_stall_hold", issue_stall, 1);
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'h00000077;
    #1;
    check("sb_mem_ready", mem_ready, 1);
    check("sb_stall_cycle_n", issue_stall, 1);
    tick();
    mem_valid = 1'b0;
    #1;
    check("sb_wr_en_n1", wr_en, 1);
    check("sb_addr_n1", addr_rd, 7);
    check("sb_data_n1", data_rd, 32'h77);
    check("sb_stall_n1", issue_stall, 1);
    tick();
    check("sb_stall_n2", issue_stall, 0);
    check("sb_busy_cleared", busy, 0);
    issue_valid = 1'b0;
    issue_rs1   = 5'd0;

    // ---------------- Same-edge set and clear ----------------
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'h00000033;
    tick();
    alu_valid   = 1'b0;
    issue_valid = 1'b1;
    issue_wb    = 1'b1;
    issue_rd    = 5'd3;
    #1;
    check("se_wr_en", wr_en, 1);
    check("se_addr", addr_rd, 3);
    check("se_issue_accept", issue_stall, 0);
    tick();
    check("se_busy3_kept", busy, 32'h0000_0008);
    #1;
    check("se_waw_stall", issue_stall, 1);
    issue_wb = 1'b0;
    #1;
    check("se_no_wb_no_stall", issue_stall, 0);
    issue_rs2 = 5'd3;
    #1;
    check("se_rs2_stall", issue_stall, 1);
    issue_rs2   = 5'd0;
    issue_valid = 1'b0;
    #1;
    check("se_invalid_no_stall", issue_stall, 0);

    // ---------------- Write to x0 ----------------
    alu_valid   = 1'b1;
    alu_rd      = 5'd0;
    alu_data    = 32'h00001234;
    issue_valid = 1'b1;
    issue_wb    = 1'b1;
    issue_rd    = 5'd0;
    issue_rs1   = 5'd0;
    issue_rs2   = 5'd0;
    #1;
    check("x0_alu_ready", alu_ready, 1);
    check("x0_issue_no_stall", issue_stall, 0);
    tick();
    alu_valid   = 1'b0;
    issue_valid = 1'b0;
    issue_wb    = 1'b0;
    check("x0_wr_en", wr_en, 0);
    check("x0_addr_hold", addr_rd, 3);
    check("x0_data_hold", data_rd, 32'h33);
    check("x0_busy", busy, 32'h0000_0008);

    // ---------------- Reset in the cycle after a grant ----------------
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h00000099;
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b1;
    mem_rd    = 5'd10;
    check("mr_wr_en_before", wr_en, 1);
    check("mr_addr_before", addr_rd, 9);
    #1;
    reset = 1'b1;
    #1;
    check("mr_wr_en_async", wr_en, 0);
    check("mr_busy_async", busy, 0);
    check("mr_addr_async", addr_rd, 0);
    check("mr_data_async", data_rd, 0);
    check("mr_mem_ready", mem_ready, 0);
    tick();
    reset     = 1'b0;
    mem_valid = 1'b0;
    tick();
    check("mr_no_lost_write", wr_en, 0);
    check("mr_addr_after", addr_rd, 0);
    check("mr_busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back controller for the register file. It arbitrates the register file's single write port between the ALU result path and the load (DMEM) result path using valid/ready handshakes. It drives registered wr_en/addr_rd/data_rd into the register file. It also keeps a per-register busy scoreboard that stalls instruction issue on operands or destinations with a pending write.

## Interface
- NUM_REG, 32, number of architectural registers; x0 is hard-wired zero.
- REG_ADDR_WIDTH, 5, register address width.
- REG_WIDTH, 32, register data width.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result request.
- alu_rd  in  REG_ADDR_WIDTH  ALU destination register.
- alu_data  in  REG_WIDTH  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  load result request.
- mem_rd  in  REG_ADDR_WIDTH  load destination register.
- mem_data  in  REG_WIDTH  load data.
- mem_ready  out  1  load request granted this cycle.
- wr_en  out  1  register file write enable (registered).
- addr_rd  out  REG_ADDR_WIDTH  register file write address (registered).
- data_rd  out  REG_WIDTH  register file write data (registered).
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2, issue_rd  in  REG_ADDR_WIDTH each  source and destination registers of that instruction.
- issue_wb  in  1  instruction writes a register.
- issue_stall  out  1  instruction must not issue this cycle.
- busy  out  NUM_REG  scoreboard vector; bit i = write to register i pending.

## Operation
- Handshake: a transfer fires when valid & ready. The requester holds valid, rd and data stable until it fires. ready is combinational from valid and arbiter state, never from rd or data.
- Arbitration: at most one grant per cycle. With a single requester, that requester is granted. With both requesting, round-robin is used: the requester not granted most recently wins. The last-grant pointer resets to MEM, so ALU wins the first conflict.
- A granted request with rd == 0 fires normally (ready=1) but produces no write: wr_en stays 0 next cycle.
- Write port register: on a grant with rd != 0, wr_en/addr_rd/data_rd load the granted rd/data for exactly one cycle. Otherwise wr_en=0 and addr_rd/data_rd hold their previous values.
- Scoreboard set: if issue_valid & issue_wb & ~issue_stall & issue_rd != 0, set busy[issue_rd] at the edge.
- Scoreboard clear: when wr_en=1, clear busy[addr_rd] at the edge, i.e. the same edge on which the register file captures the write.
- Set and clear of the same register on the same edge: set wins.
- busy[0] is always 0.
- issue_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | (issue_wb & busy[issue_rd])). This is combinational and covers RAW and WAW. Index 0 reads as not busy.
- A grant whose rd is not busy is legal and writes normally.

## Timing
- Reset (asynchronous, immediate): wr_en=0, addr_rd=0, data_rd=0, busy=0, last-grant=MEM. alu_ready and mem_ready are 0 while reset is high.
- Latency: grant in cycle N → wr_en high in cycle N+1 → register file and busy updated at end of N+1 → dependent instruction unstalls in cycle N+2.
- Throughput: one write per cycle; there are no bubbles between back-to-back grants.
- Reset asserted mid-operation: a pending wr_en is dropped, busy clears, and requesters must re-present.

## Test plan
- Reset → wr_en=0, busy=0, both readies 0. After release, alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF → alu_ready=1 same cycle; next cycle wr_en=1, addr_rd=5, data_rd=0xDEADBEEF.
- Both valid for 4 cycles (alu_rd=1, mem_rd=2, valids held until fire, then re-presented) → grants ALU, MEM, ALU, MEM; exactly one ready high per cycle.
- Issue with rd=7 and issue_wb=1 → busy[7]=1. Next instruction with rs1=7 → issue_stall=1 until mem write to 7 is granted at N; stall=0 in N+2.
- Same-edge set and clear: wr_en for reg 3 while a new issue with rd=3 is accepted → busy[3] remains 1.
- Request with rd=0 and data=0x1234 → ready=1, wr_en stays 0, busy[0] stays 0. Issue with rs1=0 never stalls.
- Assert reset in the cycle after a grant → wr_en=0 immediately, busy=0; the lost write does not appear after reset release.
